// File: rtl/watch_pkg.sv
// Shared command codes and UART byte decode for the watch control path.
// Used by the arbiter and by the watch/stopwatch control units.
package watch_pkg;

    localparam logic [1:0] CMD_CLEAR = 2'd0;
    localparam logic [1:0] CMD_MOVE  = 2'd1;
    localparam logic [1:0] CMD_INC   = 2'd2;
    localparam logic [1:0] CMD_DEC   = 2'd3;

    localparam logic [7:0] ASC_L    = 8'h4C;
    localparam logic [7:0] ASC_R    = 8'h52;
    localparam logic [7:0] ASC_U    = 8'h55;
    localparam logic [7:0] ASC_D    = 8'h44;
    localparam logic [7:0] ASC_L_LC = 8'h6C;
    localparam logic [7:0] ASC_R_LC = 8'h72;
    localparam logic [7:0] ASC_U_LC = 8'h75;
    localparam logic [7:0] ASC_D_LC = 8'h64;

    typedef struct packed {
        logic       valid;
        logic [1:0] code;
    } dec_t;

    typedef enum logic {
        ST_IDLE,
        ST_GAP
    } arb_state_t;

    function automatic dec_t decode_byte(input logic [7:0] b);
        dec_t d;
        d.valid = 1'b1;
        d.code  = CMD_CLEAR;
        unique case (1'b1)
            (b == ASC_L) || (b == ASC_L_LC): d.code = CMD_CLEAR;
            (b == ASC_R) || (b == ASC_R_LC): d.code = CMD_MOVE;
            (b == ASC_U) || (b == ASC_U_LC): d.code = CMD_INC;
            (b == ASC_D) || (b == ASC_D_LC): d.code = CMD_DEC;
            default:                         d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/watch_cmd_arbiter_fifo.sv
// Small synchronous FIFO holding 2-bit UART command codes.
// A push while full is only taken when a pop happens at the same edge.
module cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [1:0]               din,
    output logic [1:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/watch_cmd_arbiter.sv
// Merges button and UART commands into spaced, one-hot command pulses.
// Buttons use a single pending slot; UART commands queue in a FIFO.
module watch_cmd_arbiter
    import watch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_clear,
    input  logic                          btn_digit_move,
    input  logic                          btn_inc,
    input  logic                          btn_dec,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_done,
    output logic                          cmd_clear,
    output logic                          cmd_move,
    output logic                          cmd_inc,
    output logic                          cmd_dec,
    output logic                          cmd_src,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_overrun,
    output logic                          btn_overrun,
    output logic                          err_unknown
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    arb_state_t state;
    logic [7:0] gap_cnt;
    logic       pend_valid;
    logic [1:0] pend_code;
    logic [1:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    dec_t       rx_dec;
    logic       rx_ok;
    logic       btn_any;
    logic [1:0] btn_code;
    logic       consume;
    logic       pop;
    logic       push;
    logic       do_issue;
    logic [1:0] issue_code;

    assign rx_dec = decode_byte(rx_data);
    assign rx_ok  = rx_done && rx_dec.valid;

    always_comb begin
        btn_any  = btn_clear | btn_digit_move | btn_inc | btn_dec;
        btn_code = CMD_DEC;
        if (btn_clear)
            btn_code = CMD_CLEAR;
        else if (btn_digit_move)
            btn_code = CMD_MOVE;
        else if (btn_inc)
            btn_code = CMD_INC;
    end

    // The pending button always beats the FIFO at an IDLE decision.
    assign consume    = (state == ST_IDLE) && pend_valid;
    assign pop        = (state == ST_IDLE) && !pend_valid && !fifo_empty;
    assign push       = rx_ok && (!fifo_full || pop);
    assign do_issue   = consume || pop;
    assign issue_code = pend_valid ? pend_code : fifo_dout;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rx_dec.code),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            pend_valid  <= 1'b0;
            pend_code   <= CMD_CLEAR;
            cmd_clear   <= 1'b0;
            cmd_move    <= 1'b0;
            cmd_inc     <= 1'b0;
            cmd_dec     <= 1'b0;
            cmd_src     <= 1'b0;
            rx_overrun  <= 1'b0;
            btn_overrun <= 1'b0;
            err_unknown <= 1'b0;
        end else begin
            cmd_clear   <= 1'b0;
            cmd_move    <= 1'b0;
            cmd_inc     <= 1'b0;
            cmd_dec     <= 1'b0;
            rx_overrun  <= rx_ok && fifo_full && !pop;
            err_unknown <= rx_done && !rx_dec.valid;
            btn_overrun <= btn_any && pend_valid && !consume;

            if (btn_any && (!pend_valid || consume)) begin
                pend_valid <= 1'b1;
                pend_code  <= btn_code;
            end else if (consume) begin
                pend_valid <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (do_issue) begin
                        cmd_clear <= (issue_code == CMD_CLEAR);
                        cmd_move  <= (issue_code == CMD_MOVE);
                        cmd_inc   <= (issue_code == CMD_INC);
                        cmd_dec   <= (issue_code == CMD_DEC);
                        cmd_src   <= !pend_valid;
                        gap_cnt   <= GAP_LOAD;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_watch_cmd_arbiter.sv
// Self-checking bench for watch_cmd_arbiter: vector table plus
// hand-written multi-cycle sequences, with a pulse scoreboard.
module tb_watch_cmd_arbiter;
    import watch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       btn_clear, btn_digit_move, btn_inc, btn_dec;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       cmd_clear, cmd_move, cmd_inc, cmd_dec, cmd_src;
    logic [2:0] fifo_count;
    logic       rx_overrun, btn_overrun, err_unknown;

    logic       zero = 1'b0;
    logic [7:0] rx_data8;
    logic       rx_done8;
    logic       cmd_clear8, cmd_move8, cmd_inc8, cmd_dec8, cmd_src8;
    logic [2:0] fifo_count8;
    logic       rx_overrun8, btn_overrun8, err_unknown8;

    watch_cmd_arbiter #(.FIFO_DEPTH(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .btn_clear(btn_clear), .btn_digit_move(btn_digit_move),
        .btn_inc(btn_inc), .btn_dec(btn_dec),
        .rx_data(rx_data), .rx_done(rx_done),
        .cmd_clear(cmd_clear), .cmd_move(cmd_move),
        .cmd_inc(cmd_inc), .cmd_dec(cmd_dec), .cmd_src(cmd_src),
        .fifo_count(fifo_count), .rx_overrun(rx_overrun),
        .btn_overrun(btn_overrun), .err_unknown(err_unknown)
    );

    watch_cmd_arbiter #(.FIFO_DEPTH(4), .GAP_CYCLES(8)) dut8 (
        .clk(clk), .rst(rst),
        .btn_clear(zero), .btn_digit_move(zero),
        .btn_inc(zero), .btn_dec(zero),
        .rx_data(rx_data8), .rx_done(rx_done8),
        .cmd_clear(cmd_clear8), .cmd_move(cmd_move8),
        .cmd_inc(cmd_inc8), .cmd_dec(cmd_dec8), .cmd_src(cmd_src8),
        .fifo_count(fifo_count8), .rx_overrun(rx_overrun8),
        .btn_overrun(btn_overrun8), .err_unknown(err_unknown8)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] code;
        logic       src;
        int         at;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    int n_pulse = 0, err_n = 0, err_at = -1, bov_n = 0, bov_at = -1;
    int p8_n = 0, inc8_n = 0, first8_at = -1, rov8_n = 0, rov8_at = -1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (cmd_clear | cmd_move | cmd_inc | cmd_dec) begin
                n_pulse++;
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_cyc", cyc, e.at);
                    check("pulse_bits", {cmd_clear, cmd_move, cmd_inc, cmd_dec},
                          32'(4'b1000 >> e.code));
                    check("pulse_src", cmd_src, e.src);
                end
            end
            if (err_unknown) begin err_n++; err_at = cyc; end
            if (btn_overrun) begin bov_n++; bov_at = cyc; end
            if (cmd_clear8 | cmd_move8 | cmd_inc8 | cmd_dec8) begin
                p8_n++;
                if (cmd_inc8) inc8_n++;
                if (p8_n == 1) first8_at = cyc;
            end
            if (rx_overrun8) begin rov8_n++; rov8_at = cyc; end
        end
    end

    task automatic expect_cmd(input logic [1:0] code, input logic src,
                              input int at);
        exp_t e;
        e.code = code;
        e.src  = src;
        e.at   = at;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs (called at a negedge), then clear them.
    task automatic send(input logic [3:0] btn, input logic rxv,
                        input logic [7:0] b);
        {btn_clear, btn_digit_move, btn_inc, btn_dec} = btn;
        rx_done = rxv;
        rx_data = b;
        @(negedge clk);
        {btn_clear, btn_digit_move, btn_inc, btn_dec} = 4'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    typedef struct {
        logic [3:0] btn;
        logic       rxv;
        logic [7:0] b;
        logic       expv;
        logic [1:0] code;
        logic       src;
        logic       experr;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] btn, input logic rxv,
                                input logic [7:0] b, input logic expv,
                                input logic [1:0] code, input logic src,
                                input logic experr);
        vec_t v;
        v.btn = btn; v.rxv = rxv; v.b = b; v.expv = expv;
        v.code = code; v.src = src; v.experr = experr;
        return v;
    endfunction

    vec_t vecs[17];

    initial begin
        int n, e0, b0, p0;
        {btn_clear, btn_digit_move, btn_inc, btn_dec} = 4'b0;
        rx_done = 1'b0; rx_data = 8'h00;
        rx_done8 = 1'b0; rx_data8 = 8'h00;

        vecs[0]  = mk(4'b0010, 0, 8'h00, 1, CMD_INC,   0, 0);
        vecs[1]  = mk(4'b0011, 0, 8'h00, 1, CMD_INC,   0, 0);
        vecs[2]  = mk(4'b1111, 0, 8'h00, 1, CMD_CLEAR, 0, 0);
        vecs[3]  = mk(4'b0101, 0, 8'h00, 1, CMD_MOVE,  0, 0);
        vecs[4]  = mk(4'b0001, 0, 8'h00, 1, CMD_DEC,   0, 0);
        vecs[5]  = mk(4'b0000, 1, 8'h4C, 1, CMD_CLEAR, 1, 0);
        vecs[6]  = mk(4'b0000, 1, 8'h6C, 1, CMD_CLEAR, 1, 0);
        vecs[7]  = mk(4'b0000, 1, 8'h52, 1, CMD_MOVE,  1, 0);
        vecs[8]  = mk(4'b0000, 1, 8'h72, 1, CMD_MOVE,  1, 0);
        vecs[9]  = mk(4'b0000, 1, 8'h55, 1, CMD_INC,   1, 0);
        vecs[10] = mk(4'b0000, 1, 8'h75, 1, CMD_INC,   1, 0);
        vecs[11] = mk(4'b0000, 1, 8'h44, 1, CMD_DEC,   1, 0);
        vecs[12] = mk(4'b0000, 1, 8'h64, 1, CMD_DEC,   1, 0);
        vecs[13] = mk(4'b0000, 1, 8'h78, 0, CMD_CLEAR, 0, 1);
        vecs[14] = mk(4'b0000, 1, 8'h00, 0, CMD_CLEAR, 0, 1);
        vecs[15] = mk(4'b0000, 1, 8'h4D, 0, CMD_CLEAR, 0, 1);
        vecs[16] = mk(4'b0000, 0, 8'h55, 0, CMD_CLEAR, 0, 0);

        repeat (3) @(negedge clk);
        check("rst_outs", {cmd_clear, cmd_move, cmd_inc, cmd_dec, cmd_src,
                           rx_overrun, btn_overrun, err_unknown}, 0);
        check("rst_count", fifo_count, 0);
        check("rst_outs8", {cmd_clear8, cmd_move8, cmd_inc8, cmd_dec8,
                            cmd_src8, rx_overrun8}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            n = cyc + 1;
            if (vecs[i].expv)
                expect_cmd(vecs[i].code, vecs[i].src, n + 1);
            e0 = err_n;
            send(vecs[i].btn, vecs[i].rxv, vecs[i].b);
            repeat (5) @(negedge clk);
            check($sformatf("vec%0d_err", i), err_n - e0, 32'(vecs[i].experr));
            check($sformatf("vec%0d_drained", i), sb.size(), 0);
        end

        // 'R','u','U','x' back to back
        n = cyc + 1;
        expect_cmd(CMD_MOVE, 1, n + 1);
        expect_cmd(CMD_INC, 1, n + 4);
        expect_cmd(CMD_INC, 1, n + 7);
        e0 = err_n;
        send(4'b0, 1, 8'h52);
        send(4'b0, 1, 8'h75);
        send(4'b0, 1, 8'h55);
        send(4'b0, 1, 8'h78);
        repeat (8) @(negedge clk);
        check("seq3_err_n", err_n - e0, 1);
        check("seq3_err_at", err_at, n + 3);
        check("seq3_drained", sb.size(), 0);

        // button and UART at the same edge
        n = cyc + 1;
        expect_cmd(CMD_CLEAR, 0, n + 1);
        expect_cmd(CMD_INC, 1, n + 4);
        send(4'b1000, 1, 8'h55);
        repeat (6) @(negedge clk);
        check("seq5_drained", sb.size(), 0);

        // button arriving during GAP while the slot is full
        n = cyc + 1;
        b0 = bov_n;
        expect_cmd(CMD_INC, 0, n + 1);
        expect_cmd(CMD_MOVE, 0, n + 4);
        send(4'b0010, 0, 8'h00);
        @(negedge clk);
        send(4'b0100, 0, 8'h00);
        send(4'b0001, 0, 8'h00);
        repeat (6) @(negedge clk);
        check("seq6_bov_n", bov_n - b0, 1);
        check("seq6_bov_at", bov_at, n + 3);
        check("seq6_drained", sb.size(), 0);

        // slot consumed and reloaded at the same edge
        n = cyc + 1;
        b0 = bov_n;
        expect_cmd(CMD_INC, 0, n + 1);
        expect_cmd(CMD_DEC, 0, n + 4);
        send(4'b0010, 0, 8'h00);
        send(4'b0001, 0, 8'h00);
        repeat (6) @(negedge clk);
        check("seq7_bov_n", bov_n - b0, 0);
        check("seq7_drained", sb.size(), 0);

        // GAP_CYCLES=8 instance: fill, overflow, drain
        n = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            rx_data8 = 8'h55;
            rx_done8 = 1'b1;
            @(negedge clk);
            if (k == 0) check("seq4_count_e1", fifo_count8, 1);
            if (k == 1) check("seq4_count_e2", fifo_count8, 1);
            if (k == 4) check("seq4_count_e5", fifo_count8, 4);
        end
        rx_done8 = 1'b0;
        rx_data8 = 8'h00;
        repeat (45) @(negedge clk);
        check("seq4_pulses", p8_n, 5);
        check("seq4_inc_pulses", inc8_n, 5);
        check("seq4_first_at", first8_at, n + 1);
        check("seq4_rov_n", rov8_n, 1);
        check("seq4_rov_at", rov8_at, n + 5);
        check("seq4_count_end", fifo_count8, 0);

        // reset mid-stream with FIFO entries and pending button
        n = cyc + 1;
        expect_cmd(CMD_INC, 1, n + 1);
        send(4'b0, 1, 8'h55);
        send(4'b0, 1, 8'h55);
        send(4'b0, 1, 8'h55);
        send(4'b1000, 1, 8'h55);
        check("seq1_count_pre", fifo_count, 3);
        check("seq1_drained_pre", sb.size(), 0);
        rst = 1'b1;
        #1;
        check("seq1_rst_outs", {cmd_clear, cmd_move, cmd_inc, cmd_dec, cmd_src,
                                rx_overrun, btn_overrun, err_unknown}, 0);
        check("seq1_rst_count", fifo_count, 0);
        sb.delete();
        p0 = n_pulse;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("seq1_no_pulse", n_pulse - p0, 0);
        check("seq1_count_post", fifo_count, 0);

        check("final_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
